read_register_file: RTL and testbench

- Decode-stage register file with two read ports and one write port.
- Consumes the writeback stage's registered outputs (data_in, write_address) and the decoded source addresses.
- Presents the operands to execute through a registered ID/EX boundary with stall and flush control.
- Provides same-cycle write-to-read bypass and a hard-wired zero register.

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_storage.sv | 43 ++++
 rtl/read_register_file.sv | 78 +++++++
 tb/tb_read_register_file.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file constants and types shared by decode and writeback.
//   DATA_WIDTH / ADDR_WIDTH / NUM_REGS : architectural sizing
//   REG_ZERO                           : hard-wired zero register address
//   reg_addr_t / reg_data_t            : register address and data types
package rf_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_storage.sv
// Register array with one write port and two bypassed read ports.
//   clock, reset        : posedge clock, synchronous active-low clear
//   data_in             : write data
//   write_address       : write destination, zero discards the write
//   rs_addr / rt_addr   : read addresses
//   rs_rd / rt_rd       : combinational read data (zero-forced, bypassed)
module regfile_storage
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH_P = DATA_WIDTH,
   parameter int ADDR_WIDTH_P = ADDR_WIDTH,
   parameter int NUM_REGS_P   = NUM_REGS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_WIDTH_P-1:0] data_in,
   input  logic [ADDR_WIDTH_P-1:0] write_address,
   input  logic [ADDR_WIDTH_P-1:0] rs_addr,
   input  logic [ADDR_WIDTH_P-1:0] rt_addr,
   output logic [DATA_WIDTH_P-1:0] rs_rd,
   output logic [DATA_WIDTH_P-1:0] rt_rd
);

   localparam logic [ADDR_WIDTH_P-1:0] ZERO = ADDR_WIDTH_P'(REG_ZERO);

   logic [DATA_WIDTH_P-1:0] regs [NUM_REGS_P];

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS_P; i++) regs[i] <= '0;
      end else if (write_address != ZERO) begin
         regs[write_address] <= data_in;
      end
   end

   // A write landing this cycle is visible to a read of the same register.
   assign rs_rd = (rs_addr == ZERO)          ? '0      :
                  (rs_addr == write_address) ? data_in : regs[rs_addr];
   assign rt_rd = (rt_addr == ZERO)          ? '0      :
                  (rt_addr == write_address) ? data_in : regs[rt_addr];

endmodule

// File: rtl/read_register_file.sv
// Decode-stage register file feeding a registered ID/EX boundary.
//   clock, reset              : posedge clock, synchronous active-low reset
//   data_in, write_address    : writeback port (address 0 = no write)
//   rs_addr, rt_addr          : decoded source addresses
//   id_valid                  : decode slot holds a real instruction
//   stall, flush              : hold / bubble the ID/EX register (flush wins)
//   rs_data, rt_data          : registered operands
//   rs_addr_ex, rt_addr_ex    : registered source addresses for forwarding
//   ex_valid                  : ID/EX slot valid
module read_register_file
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH_P = DATA_WIDTH,
   parameter int ADDR_WIDTH_P = ADDR_WIDTH,
   parameter int NUM_REGS_P   = NUM_REGS
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_WIDTH_P-1:0] data_in,
   input  logic [ADDR_WIDTH_P-1:0] write_address,
   input  logic [ADDR_WIDTH_P-1:0] rs_addr,
   input  logic [ADDR_WIDTH_P-1:0] rt_addr,
   input  logic                    id_valid,
   input  logic                    stall,
   input  logic                    flush,
   output logic [DATA_WIDTH_P-1:0] rs_data,
   output logic [DATA_WIDTH_P-1:0] rt_data,
   output logic [ADDR_WIDTH_P-1:0] rs_addr_ex,
   output logic [ADDR_WIDTH_P-1:0] rt_addr_ex,
   output logic                    ex_valid
);

   localparam logic [ADDR_WIDTH_P-1:0] ZERO = ADDR_WIDTH_P'(REG_ZERO);

   logic [DATA_WIDTH_P-1:0] rs_rd, rt_rd;

   regfile_storage #(
      .DATA_WIDTH_P (DATA_WIDTH_P),
      .ADDR_WIDTH_P (ADDR_WIDTH_P),
      .NUM_REGS_P   (NUM_REGS_P)
   ) u_storage (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .write_address (write_address),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rs_rd         (rs_rd),
      .rt_rd         (rt_rd)
   );

   // A held operand whose source register is written during the stall
   // picks up the new value, so it is current when the stall releases.
   logic rs_refresh, rt_refresh;
   assign rs_refresh = (rs_addr_ex != ZERO) && (rs_addr_ex == write_address);
   assign rt_refresh = (rt_addr_ex != ZERO) && (rt_addr_ex == write_address);

   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         rs_data    <= '0;
         rt_data    <= '0;
         rs_addr_ex <= '0;
         rt_addr_ex <= '0;
         ex_valid   <= 1'b0;
      end else if (stall) begin
         if (rs_refresh) rs_data <= data_in;
         if (rt_refresh) rt_data <= data_in;
      end else begin
         // Bubbles still carry data; ex_valid tells execute to ignore it.
         rs_data    <= rs_rd;
         rt_data    <= rt_rd;
         rs_addr_ex <= rs_addr;
         rt_addr_ex <= rt_addr;
         ex_valid   <= id_valid;
      end
   end

endmodule

// File: tb/tb_read_register_file.sv
module tb_read_register_file;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic [4:0]  write_address, rs_addr, rt_addr;
   logic        id_valid, stall, flush;
   logic [31:0] rs_data, rt_data;
   logic [4:0]  rs_addr_ex, rt_addr_ex;
   logic        ex_valid;

   always #5 clock = ~clock;

   read_register_file dut (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .write_address (write_address),
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .id_valid      (id_valid),
      .stall         (stall),
      .flush         (flush),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .rs_addr_ex    (rs_addr_ex),
      .rt_addr_ex    (rt_addr_ex),
      .ex_valid      (ex_valid)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: architectural registers plus expected ID/EX contents.
   logic [31:0] mem [32];
   logic [31:0] e_rs, e_rt;
   logic [4:0]  e_rsa, e_rta;
   logic        e_v;

   function automatic logic [31:0] model_read(input logic [4:0] a,
                                              input logic [4:0] wa,
                                              input logic [31:0] d);
      if (a == 0) return 32'h0;
      if (a == wa) return d;
      return mem[a];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, advance model and DUT, compare all outputs.
   task automatic step(input logic rst, input logic [31:0] d, input logic [4:0] wa,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic idv, input logic stl, input logic fl);
      logic [31:0] ra, rb;
      reset = rst; data_in = d; write_address = wa;
      rs_addr = rs; rt_addr = rt; id_valid = idv; stall = stl; flush = fl;
      if (!rst) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         e_rs = 0; e_rt = 0; e_rsa = 0; e_rta = 0; e_v = 0;
      end else begin
         ra = model_read(rs, wa, d);
         rb = model_read(rt, wa, d);
         if (fl) begin
            e_rs = 0; e_rt = 0; e_rsa = 0; e_rta = 0; e_v = 0;
         end else if (stl) begin
            if (e_rsa != 0 && e_rsa == wa) e_rs = d;
            if (e_rta != 0 && e_rta == wa) e_rt = d;
         end else begin
            e_rs = ra; e_rt = rb; e_rsa = rs; e_rta = rt; e_v = idv;
         end
         if (wa != 0) mem[wa] = d;
      end
      @(posedge clock);
      #1;
      chk("model rs_data",    rs_data,           e_rs);
      chk("model rt_data",    rt_data,           e_rt);
      chk("model rs_addr_ex", 32'(rs_addr_ex),   32'(e_rsa));
      chk("model rt_addr_ex", 32'(rt_addr_ex),   32'(e_rta));
      chk("model ex_valid",   32'(ex_valid),     32'(e_v));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      e_rs = 0; e_rt = 0; e_rsa = 0; e_rta = 0; e_v = 0;
      reset = 0; data_in = 0; write_address = 0; rs_addr = 0; rt_addr = 0;
      id_valid = 0; stall = 0; flush = 0;
      @(negedge clock);

      // Reset state
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset ex_valid", 32'(ex_valid), 32'h0);
      chk("reset rs_data", rs_data, 32'h0);

      // Fill 1..31, then reset clears everything including a same-cycle load
      for (int i = 1; i < 32; i++) step(1, 32'h1000_0000 + i, 5'(i), 0, 0, 0, 0, 0);
      step(0, 32'hFFFF_0000, 5'd6, 5'd5, 5'd9, 1, 0, 0);
      step(1, 0, 0, 5'd5, 5'd9, 0, 0, 0);
      chk("post-reset rs5", rs_data, 32'h0);
      chk("post-reset rt9", rt_data, 32'h0);
      chk("post-reset ex_valid", 32'(ex_valid), 32'h0);

      // Write then read next cycle
      step(1, 32'hDEADBEEF, 5'd5, 0, 0, 0, 0, 0);
      step(1, 0, 0, 5'd5, 0, 1, 0, 0);
      chk("rd5 data", rs_data, 32'hDEADBEEF);
      chk("rd5 addr", 32'(rs_addr_ex), 32'd5);
      chk("rd5 valid", 32'(ex_valid), 32'h1);

      // Same-cycle bypass
      step(1, 32'h12345678, 5'd7, 0, 5'd7, 1, 0, 0);
      chk("bypass rt7", rt_data, 32'h12345678);
      step(1, 0, 0, 5'd7, 0, 1, 0, 0);
      chk("later rd7", rs_data, 32'h12345678);

      // Zero register
      step(1, 32'hFFFFFFFF, 5'd0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0, 0);
      chk("zero rs", rs_data, 32'h0);
      chk("zero rt", rt_data, 32'h0);

      // Stall with refresh of held operand
      step(1, 32'h11111111, 5'd3, 0, 0, 0, 0, 0);
      step(1, 0, 0, 5'd3, 0, 1, 0, 0);
      chk("load rs3", rs_data, 32'h11111111);
      step(1, 32'hA5A5A5A5, 5'd3, 5'd9, 5'd9, 0, 1, 0);
      chk("stall refresh", rs_data, 32'hA5A5A5A5);
      step(1, 0, 0, 5'd12, 5'd12, 0, 1, 0);
      step(1, 0, 0, 5'd12, 5'd12, 0, 1, 0);
      chk("stall hold addr", 32'(rs_addr_ex), 32'd3);
      chk("stall hold valid", 32'(ex_valid), 32'h1);
      chk("stall hold data", rs_data, 32'hA5A5A5A5);

      // Stall + flush: flush wins, write still lands
      step(1, 32'h0BADF00D, 5'd4, 5'd4, 5'd4, 1, 1, 1);
      chk("flush valid", 32'(ex_valid), 32'h0);
      chk("flush rs", rs_data, 32'h0);
      chk("flush rsa", 32'(rs_addr_ex), 32'h0);
      step(1, 0, 0, 5'd4, 0, 1, 0, 0);
      chk("after flush rd4", rs_data, 32'h0BADF00D);

      // Randomized traffic; small address pool makes bypass/refresh common
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] wa, ra, rb;
         wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
         ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
         rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
         step(($urandom_range(0, 99) != 0), $urandom, wa, ra, rb,
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
